// File: rtl/rx_pipe.sv
// ---------------------------------------------------------------------------
// rx_pipe: receive half of the UART link.
//
// Deserialises 8N1 frames arriving on the asynchronous rx line and buffers
// the received bytes in a first-word-fall-through FIFO. The design has three
// stages:
//   - a 2-FF synchroniser that brings rx into the clk domain (rx_s)
//   - a receive FSM that samples each bit at its centre
//   - a DEPTH-entry FIFO drained by the consumer through pop_front
//
// Handshake: the consumer may assert pop_front in any cycle. A pop takes
// effect at the next posedge only if the FIFO is non-empty. data_out is the
// head byte and is valid whenever empty is low.
//
// Ports:
//   clk            in   1      clock
//   rst            in   1      synchronous, active-high reset
//   rx             in   1      asynchronous serial line, idle high
//   pop_front      in   1      remove the head byte this cycle
//   data_out       out  WIDTH  head byte (0 while empty)
//   empty          out  1      FIFO holds no bytes
//   full           out  1      FIFO holds DEPTH bytes
//   framing_error  out  1      sticky: a stop bit was sampled low
//   overrun        out  1      sticky: a byte was dropped because FIFO full
//   underflow      out  1      sticky: pop_front was asserted while empty
// ---------------------------------------------------------------------------
module rx_pipe #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 9_600,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       pop_front,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       framing_error,
    output logic       overrun,
    output logic       underflow
);

    localparam int WIDTH        = 8;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(DEPTH);
    localparam int CW           = PW + 1;

    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------------
    // Synchroniser. Both stages reset to 1 so a reset never looks like a
    // start bit.
    // ---------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rx_s;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    assign rx_s = sync2_q;

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   framing_q, framing_d;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        framing_d = framing_q;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end
            end
            S_START: begin
                // Half a bit in: a real start bit is still low here,
                // a short glitch has already returned high.
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        framing_d = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new frame.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             underflow_q, underflow_d;
    logic             pop_ok;
    logic             push_ok;

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted when the consumer is popping.
    assign pop_ok  = pop_front && (count_q != '0);
    assign push_ok = push_q && ((count_q != DEPTH_C) || pop_front);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        if (push_q && !push_ok) begin
            overrun_d = 1'b1;
        end
        if (pop_front && (count_q == '0)) begin
            underflow_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            framing_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            framing_q   <= framing_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign empty         = (count_q == '0);
    assign full          = (count_q == DEPTH_C);
    assign data_out      = empty ? '0 : mem_q[rd_ptr_q];
    assign framing_error = framing_q;
    assign overrun       = overrun_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_rx_pipe.sv
// ---------------------------------------------------------------------------
// tb_rx_pipe: directed bench for rx_pipe with CLKS_PER_BIT=10, DEPTH=4.
// Inputs change 1 ns after a posedge; outputs are checked at the negedge.
// ---------------------------------------------------------------------------
module tb_rx_pipe;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       pop_front;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       framing_error;
  logic       overrun;
  logic       underflow;

  int n_cmp;
  int n_err;
  int lat;

  rx_pipe #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .pop_front    (pop_front),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .framing_error(framing_error),
    .overrun      (overrun),
    .underflow    (underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // start bit, 8 data bits LSB first, stop bit, optional extra low time,
  // then line back high
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int tail_low);
    rx = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(10);
    end
    rx = stop_val;
    wait_clk(10);
    if (tail_low > 0) begin
      rx = 1'b0;
      wait_clk(tail_low);
    end
    rx = 1'b1;
  endtask

  task automatic pop_one();
    pop_front = 1'b1;
    wait_clk(1);
    pop_front = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic fe,
                             input logic ov, input logic uf);
    check({tag, "_framing"}, {31'd0, framing_error}, {31'd0, fe});
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, ov});
    check({tag, "_underflow"}, {31'd0, underflow}, {31'd0, uf});
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    rx        = 1'b1;
    pop_front = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    sample();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    wait_clk(5);

    // 1: single byte, latency start edge -> !empty = 2 + 95 + 2 = 99
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        for (int i = 1; i <= 150 && lat == 0; i++) begin
          @(posedge clk);
          #1;
          if (!empty) lat = i;
        end
      end
    join
    check("t1_latency_ok", {31'd0, (lat >= 98 && lat <= 100)}, 32'd1);
    sample();
    check("t1_data", {24'd0, data_out}, 32'hA5);
    check("t1_empty", {31'd0, empty}, 32'd0);
    pop_one();
    sample();
    check("t1_empty_after_pop", {31'd0, empty}, 32'd1);
    wait_clk(3);

    // 2: four back-to-back bytes fill the FIFO
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h80, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    sample();
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_head", {24'd0, data_out}, 32'h01);
    check_flags("t2", 1'b0, 1'b0, 1'b0);

    // 5b: push and pop in the same cycle while full. Push strobe is
    // high in the cycle after the stop sample (posedge 98), so pop must
    // be high at posedge 99.
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        wait_clk(98);
        pop_front = 1'b1;
        wait_clk(1);
        pop_front = 1'b0;
      end
    join
    sample();
    check("t5_full_kept", {31'd0, full}, 32'd1);
    check("t5_no_overrun", {31'd0, overrun}, 32'd0);
    check("t5_head_adv", {24'd0, data_out}, 32'h80);

    // 3: byte arriving while full is dropped
    send_frame(8'h3C, 1'b1, 0);
    sample();
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_pop0", {24'd0, data_out}, 32'h80);
    pop_one();
    sample();
    check("t3_pop1", {24'd0, data_out}, 32'hFF);
    pop_one();
    sample();
    check("t3_pop2", {24'd0, data_out}, 32'h00);
    pop_one();
    sample();
    check("t3_pop3", {24'd0, data_out}, 32'h5A);
    pop_one();
    sample();
    check("t3_empty", {31'd0, empty}, 32'd1);
    check("t3_no_underflow", {31'd0, underflow}, 32'd0);

    // 5a: pop while empty
    pop_one();
    sample();
    check("t5_underflow", {31'd0, underflow}, 32'd1);
    check("t5_still_empty", {31'd0, empty}, 32'd1);
    check("t5_data_zero", {24'd0, data_out}, 32'h0);

    // 4: 3-clock glitch rejected
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(30);
    sample();
    check("t4_glitch_empty", {31'd0, empty}, 32'd1);
    check("t4_glitch_no_fe", {31'd0, framing_error}, 32'd0);

    // 4: bad stop bit, line held low a further 30 clk
    send_frame(8'h55, 1'b0, 30);
    wait_clk(6);
    sample();
    check("t4_framing", {31'd0, framing_error}, 32'd1);
    check("t4_fe_empty", {31'd0, empty}, 32'd1);
    send_frame(8'h66, 1'b1, 0);
    sample();
    check("t4_recover_empty", {31'd0, empty}, 32'd0);
    check("t4_recover_data", {24'd0, data_out}, 32'h66);
    pop_one();
    wait_clk(3);

    // 6: reset in the middle of the data bits of 0x99
    rx = 1'b0;
    wait_clk(10);
    rx = 1'b1;
    wait_clk(10);
    rx = 1'b0;
    wait_clk(10);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    rx  = 1'b1;
    wait_clk(20);
    sample();
    check("t6_empty", {31'd0, empty}, 32'd1);
    check_flags("t6", 1'b0, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 0);
    sample();
    check("t6_data", {24'd0, data_out}, 32'h42);
    check("t6_not_empty", {31'd0, empty}, 32'd0);
    check("t6_no_fe", {31'd0, framing_error}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
